ctrl_pipe: RTL
==============

# ctrl_pipe

Carries the decoded control bundle from the decode stage through the EX, MEM and WB pipeline registers of the 5-stage RV32 core (integer plus single-precision FP subset). It is the consuming end of the opcode decoder's control outputs. It also owns stage sequencing:
- load-use interlock;
- branch/jump squash;
- global freeze on memory-bus stall.

All bubble/flush policy for control signals lives here; datapath registers use its stall/flush outputs.

## Interface
Parameters:
- REG_W, 5, register index width (x and f files).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_ctrl  in  ctrl_id_t  decoder outputs: ALUOp[2:0], Branch[1:0], PCtoRegSrc, RDSrc, ALUSrc, MemtoReg, MemWrite, MemRead, RegWrite, Rs1Sel, Rs2Sel, ALUSel, FRegWrite.
- id_rd, id_rs1, id_rs2  in  REG_W each  register indices.
- id_rs1_used, id_rs2_used  in  1  operand actually read.
- ex_branch_taken  in  1  EX resolved a taken branch, JAL or JALR.
- mem_stall  in  1  instruction or data bus not ready.
- ex_ctrl, mem_ctrl, wb_ctrl  out  ctrl_ex_t / ctrl_mem_t / ctrl_wb_t  per-stage control.
- ex_rd, mem_rd, wb_rd  out  REG_W each.
- ex_valid, mem_valid, wb_valid  out  1 each.
- pc_hold  out  1  hold PC and the IF/ID register.
- ifid_flush  out  1  squash the IF/ID register.

## Operation
- **Bubble encoding:** ALUOp=3'b010 (ADD), Branch=2'b00, all single-bit fields 0, valid=0, rd=0. Reset loads the bubble into every stage.
- **Stage contents:**
  - ctrl_ex_t carries everything except ImmType.
  - ctrl_mem_t carries MemRead, MemWrite, MemtoReg, RegWrite, FRegWrite, RDSrc.
  - ctrl_wb_t carries MemtoReg, RegWrite, FRegWrite.
- **Load-use hazard:** `lu` asserts when all of the following hold:
  - ex_valid & ex_ctrl.MemRead & id_valid;
  - an ID operand matches ex_rd in the same register class. rs1 matches when id_rs1_used, id_rs1==ex_rd, and Rs1Sel equals the EX FRegWrite. rs2 matches likewise using Rs2Sel.
  - an integer target x0 never matches; f0 does match.
- **Priority per cycle:**
  1. **mem_stall:** all stage registers hold. pc_hold=1, ifid_flush=0.
  2. **ex_branch_taken:** ID is squashed, so a bubble enters EX. ifid_flush=1, pc_hold=0. EX→MEM and MEM→WB advance normally. lu is ignored.
  3. **lu:** a bubble enters EX. pc_hold=1, ifid_flush=0. EX→MEM and MEM→WB advance.
  4. **Otherwise:** all stages advance. ID enters EX with ex_valid=id_valid. When id_valid=0, a bubble enters.
- Valid=0 in any stage forces its RegWrite, FRegWrite and MemWrite to 0 at the outputs.

## Timing
- pc_hold and ifid_flush are combinational from the current-cycle inputs and EX registers. They carry no registered delay.
- Stage registers update on posedge clk. Latency ID→EX→MEM→WB is 1 cycle per stage.
- A load-use stall lasts exactly 1 cycle: the next cycle EX holds the bubble, so lu deasserts.
- A taken branch costs 2 slots: the EX-resident branch's successors in ID and IF. IF is discarded by the fetch unit on redirect.
- While mem_stall is high, all outputs are stable.
- Asserting rst mid-operation clears all stages to bubble asynchronously. Outputs are valid bubble values while rst is high.

## Structure
- Package `cpu_ctrl_pkg`: the ALUOp codes, Branch codes and ImmType codes; the structs ctrl_id_t, ctrl_ex_t, ctrl_mem_t and ctrl_wb_t; and a BUBBLE_* constant for each struct. The decoder is refactored to use the same package.
- One combinational sub-module, `load_use_detect`, computes lu. Stage registers and priority logic live in ctrl_pipe.

## Test plan
- **Reset:** assert rst for 2 cycles mid-stream → all *_valid=0, ALUOp=3'b010 in every stage, pc_hold=0, ifid_flush=0.
- **Straight-line flow:** an R-type (RegWrite=1, rd=5) followed by an I-type (rd=6) → the R-type appears in EX, MEM and WB on cycles 1, 2 and 3 with rd=5. No stalls.
- **Integer load-use:**
  - LW rd=7 followed by ADD rs1=7 → pc_hold=1 for 1 cycle; a bubble follows LW in MEM; ADD enters EX one cycle late.
  - Repeating with rd=0 produces no stall.
- **FP load-use:**
  - FLW f3 followed by FADD rs2=f3 (Rs2Sel=1) → 1-cycle stall.
  - LW x3 followed by FADD rs2=f3 → no stall, because the register classes differ.
- **Branch vs load-use:**
  - A taken branch in EX coinciding with lu in ID → ifid_flush=1, pc_hold=0, and a bubble enters EX.
  - The following cycle, no stall is asserted.
- **Memory stall:** hold mem_stall for 3 cycles during a load-use condition → all stage outputs frozen for 3 cycles. Then the 1-cycle load-use stall executes normally.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-bundle types for the RV32 decode/pipeline boundary: opcode field
// codes, per-stage control structs, their bubble values and stage-to-stage projections.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SLT = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_JAL  = 2'b10,
        BR_JALR = 2'b11
    } branch_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_e;

    typedef struct packed {
        alu_op_e alu_op;
        branch_e branch;
        imm_e    imm_type;
        logic    pc_to_reg_src;
        logic    rd_src;
        logic    alu_src;
        logic    mem_to_reg;
        logic    mem_write;
        logic    mem_read;
        logic    reg_write;
        logic    rs1_sel;
        logic    rs2_sel;
        logic    alu_sel;
        logic    freg_write;
    } ctrl_id_t;

    typedef struct packed {
        alu_op_e alu_op;
        branch_e branch;
        logic    pc_to_reg_src;
        logic    rd_src;
        logic    alu_src;
        logic    mem_to_reg;
        logic    mem_write;
        logic    mem_read;
        logic    reg_write;
        logic    rs1_sel;
        logic    rs2_sel;
        logic    alu_sel;
        logic    freg_write;
    } ctrl_ex_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
        logic freg_write;
        logic rd_src;
    } ctrl_mem_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic freg_write;
    } ctrl_wb_t;

    localparam ctrl_id_t BUBBLE_ID = '{
        alu_op: ALU_ADD, branch: BR_NONE, imm_type: IMM_I,
        pc_to_reg_src: 1'b0, rd_src: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
        mem_write: 1'b0, mem_read: 1'b0, reg_write: 1'b0, rs1_sel: 1'b0,
        rs2_sel: 1'b0, alu_sel: 1'b0, freg_write: 1'b0
    };

    localparam ctrl_ex_t BUBBLE_EX = '{
        alu_op: ALU_ADD, branch: BR_NONE,
        pc_to_reg_src: 1'b0, rd_src: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
        mem_write: 1'b0, mem_read: 1'b0, reg_write: 1'b0, rs1_sel: 1'b0,
        rs2_sel: 1'b0, alu_sel: 1'b0, freg_write: 1'b0
    };

    localparam ctrl_mem_t BUBBLE_MEM = '{
        mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
        reg_write: 1'b0, freg_write: 1'b0, rd_src: 1'b0
    };

    localparam ctrl_wb_t BUBBLE_WB = '{mem_to_reg: 1'b0, reg_write: 1'b0, freg_write: 1'b0};

    // The immediate type is consumed in decode, so it is dropped at ID/EX.
    function automatic ctrl_ex_t to_ex(input ctrl_id_t c);
        ctrl_ex_t r;
        r.alu_op        = c.alu_op;
        r.branch        = c.branch;
        r.pc_to_reg_src = c.pc_to_reg_src;
        r.rd_src        = c.rd_src;
        r.alu_src       = c.alu_src;
        r.mem_to_reg    = c.mem_to_reg;
        r.mem_write     = c.mem_write;
        r.mem_read      = c.mem_read;
        r.reg_write     = c.reg_write;
        r.rs1_sel       = c.rs1_sel;
        r.rs2_sel       = c.rs2_sel;
        r.alu_sel       = c.alu_sel;
        r.freg_write    = c.freg_write;
        return r;
    endfunction

    function automatic ctrl_mem_t to_mem(input ctrl_ex_t c);
        ctrl_mem_t r;
        r.mem_read   = c.mem_read;
        r.mem_write  = c.mem_write;
        r.mem_to_reg = c.mem_to_reg;
        r.reg_write  = c.reg_write;
        r.freg_write = c.freg_write;
        r.rd_src     = c.rd_src;
        return r;
    endfunction

    function automatic ctrl_wb_t to_wb(input ctrl_mem_t c);
        ctrl_wb_t r;
        r.mem_to_reg = c.mem_to_reg;
        r.reg_write  = c.reg_write;
        r.freg_write = c.freg_write;
        return r;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read,
// in the same register class, by the instruction in ID.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic             ex_freg_write,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_rs1_sel,
    input  logic             id_rs2_sel,
    output logic             lu
);

    logic target_real;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero so it never carries a dependency; f0 is a real register.
    assign target_real = ex_freg_write | (ex_rd != '0);

    assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd) && (id_rs1_sel == ex_freg_write);
    assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd) && (id_rs2_sel == ex_freg_write);

    assign lu = ex_valid && ex_mem_read && id_valid && target_real && (rs1_hit || rs2_hit);

endmodule

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline registers (ID/EX, EX/MEM, MEM/WB) plus stage sequencing:
// memory-stall freeze, taken-branch squash and load-use interlock.
module ctrl_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  ctrl_id_t         id_ctrl,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_branch_taken,
    input  logic             mem_stall,
    output ctrl_ex_t         ex_ctrl,
    output ctrl_mem_t        mem_ctrl,
    output ctrl_wb_t         wb_ctrl,
    output logic [REG_W-1:0] ex_rd,
    output logic [REG_W-1:0] mem_rd,
    output logic [REG_W-1:0] wb_rd,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             pc_hold,
    output logic             ifid_flush
);

    ctrl_ex_t         ex_q;
    ctrl_mem_t        mem_q;
    ctrl_wb_t         wb_q;
    logic [REG_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic             ex_valid_q, mem_valid_q, wb_valid_q;
    logic             lu;
    logic             ex_bubble;

    load_use_detect #(.REG_W(REG_W)) u_lu (
        .ex_valid      (ex_valid_q),
        .ex_mem_read   (ex_q.mem_read),
        .ex_freg_write (ex_q.freg_write),
        .ex_rd         (ex_rd_q),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rs1_sel    (id_ctrl.rs1_sel),
        .id_rs2_sel    (id_ctrl.rs2_sel),
        .lu            (lu)
    );

    // A branch squash outranks the interlock: the stalled instruction is discarded anyway.
    assign pc_hold    = !rst && (mem_stall || (!ex_branch_taken && lu));
    assign ifid_flush = !rst && !mem_stall && ex_branch_taken;
    assign ex_bubble  = ex_branch_taken || lu || !id_valid;

    // NOTE: every pipeline register is in the async reset so each stage comes up as a
    // bubble; the state updates use non-blocking assignments so all stages shift together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= BUBBLE_EX;
            mem_q       <= BUBBLE_MEM;
            wb_q        <= BUBBLE_WB;
            ex_rd_q     <= '0;
            mem_rd_q    <= '0;
            wb_rd_q     <= '0;
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
        end else if (!mem_stall) begin
            wb_q        <= to_wb(mem_q);
            wb_rd_q     <= mem_rd_q;
            wb_valid_q  <= mem_valid_q;
            mem_q       <= to_mem(ex_q);
            mem_rd_q    <= ex_rd_q;
            mem_valid_q <= ex_valid_q;
            if (ex_bubble) begin
                ex_q       <= BUBBLE_EX;
                ex_rd_q    <= '0;
                ex_valid_q <= 1'b0;
            end else begin
                ex_q       <= to_ex(id_ctrl);
                ex_rd_q    <= id_rd;
                ex_valid_q <= 1'b1;
            end
        end
    end

    // NOTE: outputs start from the registered value before masking, so no path leaves
    // a field unassigned and no latch is inferred.
    always_comb begin
        ex_ctrl            = ex_q;
        ex_ctrl.reg_write  = ex_q.reg_write  & ex_valid_q;
        ex_ctrl.freg_write = ex_q.freg_write & ex_valid_q;
        ex_ctrl.mem_write  = ex_q.mem_write  & ex_valid_q;

        mem_ctrl            = mem_q;
        mem_ctrl.reg_write  = mem_q.reg_write  & mem_valid_q;
        mem_ctrl.freg_write = mem_q.freg_write & mem_valid_q;
        mem_ctrl.mem_write  = mem_q.mem_write  & mem_valid_q;

        wb_ctrl            = wb_q;
        wb_ctrl.reg_write  = wb_q.reg_write  & wb_valid_q;
        wb_ctrl.freg_write = wb_q.freg_write & wb_valid_q;
    end

    assign ex_rd     = ex_rd_q;
    assign mem_rd    = mem_rd_q;
    assign wb_rd     = wb_rd_q;
    assign ex_valid  = ex_valid_q;
    assign mem_valid = mem_valid_q;
    assign wb_valid  = wb_valid_q;

endmodule
